// File: rtl/led_pkg.sv
// Shared definitions for the LED pattern generator: channel modes, breathe FSM
// states, duty width and the half-period clamp.
package led_pkg;

    localparam int DUTY_W = 8;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'b00,
        MODE_ON      = 2'b01,
        MODE_BLINK   = 2'b10,
        MODE_BREATHE = 2'b11
    } led_mode_e;

    typedef enum logic {
        BR_UP   = 1'b0,
        BR_DOWN = 1'b1
    } breathe_state_e;

    // A half-period of zero behaves exactly like one.
    function automatic logic [15:0] eff_half_period(input logic [15:0] hp);
        return (hp == 16'd0) ? 16'd1 : hp;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Timebase prescaler: counts 0..DIV-1 and flags the last count as a one-cycle tick.
module led_tick_gen #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 1_000
) (
    input  logic sys_clk50m,
    input  logic sys_rst_n,
    output logic tick
);

    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        // NOTE: assign a default before any branch so no path leaves cnt_d unassigned (no latch).
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
            cnt_d = '0;
        end
    end

    // NOTE: async active-low reset in the sensitivity list; flops update with <= so all
    // registers sample pre-edge values instead of chaining through one another.
    always_ff @(posedge sys_clk50m or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED driver: OFF / ON / complementary BLINK / PWM BREATHE, all
// channels sharing one free-running timebase so mode switches stay phase-aligned.
module led_pattern_gen
    import led_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int TICK_HZ    = 1_000,
    parameter int N_LED      = 2,
    parameter int ACTIVE_LOW = 0
) (
    input  logic                 sys_clk50m,
    input  logic                 sys_rst_n,
    input  logic [2*N_LED-1:0]   mode,
    input  logic [15:0]          half_period,
    output logic [N_LED-1:0]     led,
    output logic                 tick,
    output logic                 phase
);

    localparam logic AL = (ACTIVE_LOW != 0);

    logic [15:0]       pcnt_q, pcnt_d;
    logic              phase_q, phase_d;
    logic [15:0]       hp_lim;
    logic [DUTY_W-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [DUTY_W-1:0] duty_q;
    breathe_state_e    state_q;
    logic [N_LED-1:0]  led_q, led_d;

    led_tick_gen #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ)
    ) u_tick_gen (
        .sys_clk50m (sys_clk50m),
        .sys_rst_n  (sys_rst_n),
        .tick       (tick)
    );

    assign hp_lim = eff_half_period(half_period);

    // Compare with >= so a count left above a freshly lowered limit wraps on the next tick.
    always_comb begin
        pcnt_d  = pcnt_q;
        phase_d = phase_q;
        if (tick) begin
            if (pcnt_q >= hp_lim - 16'd1) begin
                pcnt_d  = 16'd0;
                phase_d = ~phase_q;
            end else begin
                pcnt_d = pcnt_q + 16'd1;
            end
        end
    end

    assign pwm_cnt_d = pwm_cnt_q + DUTY_W'(1);

    always_ff @(posedge sys_clk50m or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pcnt_q    <= 16'd0;
            phase_q   <= 1'b0;
            pwm_cnt_q <= '0;
        end else begin
            pcnt_q    <= pcnt_d;
            phase_q   <= phase_d;
            pwm_cnt_q <= pwm_cnt_d;
        end
    end

    // Triangle ramp; endpoints reverse immediately rather than being held for a tick.
    always_ff @(posedge sys_clk50m or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= BR_UP;
            duty_q  <= '0;
        end else if (tick) begin
            unique case (state_q)
                BR_UP: begin
                    if (duty_q == '1) begin
                        state_q <= BR_DOWN;
                        duty_q  <= duty_q - DUTY_W'(1);
                    end else begin
                        duty_q  <= duty_q + DUTY_W'(1);
                    end
                end
                BR_DOWN: begin
                    if (duty_q == '0) begin
                        state_q <= BR_UP;
                        duty_q  <= DUTY_W'(1);
                    end else begin
                        duty_q  <= duty_q - DUTY_W'(1);
                    end
                end
            endcase
        end
    end

    always_comb begin
        led_d = '0;
        for (int i = 0; i < N_LED; i++) begin
            logic lv;
            lv = 1'b0;
            unique case (led_mode_e'(mode[2*i +: 2]))
                MODE_OFF:     lv = 1'b0;
                MODE_ON:      lv = 1'b1;
                MODE_BLINK:   lv = (i % 2 == 0) ? ~phase_q : phase_q;
                MODE_BREATHE: lv = (pwm_cnt_q < duty_q);
            endcase
            led_d[i] = lv ^ AL;
        end
    end

    always_ff @(posedge sys_clk50m or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            led_q <= {N_LED{AL}};
        end else begin
            led_q <= led_d;
        end
    end

    assign led   = led_q;
    assign phase = phase_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Self-checking bench: two generator instances (DIV=10 active-high, DIV=2 active-low)
// compared each cycle against a tick-counting reference model.
module tb_led_pattern_gen;
    import led_pkg::*;

    localparam int DIV_A = 10;
    localparam int DIV_B = 2;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;

    logic [3:0]  mode_a = 4'b0101;
    logic [15:0] hp_a   = 16'd1;
    logic [1:0]  led_a;
    logic        tick_a, phase_a;

    logic [7:0]  mode_b = 8'h55;
    logic [15:0] hp_b   = 16'd1;
    logic [3:0]  led_b;
    logic        tick_b, phase_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    led_pattern_gen #(.CLK_HZ(100), .TICK_HZ(10), .N_LED(2), .ACTIVE_LOW(0)) dut_a (
        .sys_clk50m (clk), .sys_rst_n (rst_n), .mode (mode_a), .half_period (hp_a),
        .led (led_a), .tick (tick_a), .phase (phase_a)
    );

    led_pattern_gen #(.CLK_HZ(2), .TICK_HZ(1), .N_LED(4), .ACTIVE_LOW(1)) dut_b (
        .sys_clk50m (clk), .sys_rst_n (rst_n), .mode (mode_b), .half_period (hp_b),
        .led (led_b), .tick (tick_b), .phase (phase_b)
    );

    // Reference model: e = edges since release, ticks = ticks consumed,
    // pcnt = ticks since last phase toggle, lv = logical led value (before polarity).
    typedef struct {
        int          e;
        int          ticks;
        int          pcnt;
        bit          ph;
        logic [15:0] lv;
    } model_t;

    model_t ma, mb;

    function automatic int tri_duty(input int n);
        int m;
        m = n % 510;
        return (m <= 255) ? m : 510 - m;
    endfunction

    function automatic logic logic_val(input logic [1:0] md, input int ch, input bit ph,
                                       input int duty, input int pwm);
        case (md)
            2'b00:   return 1'b0;
            2'b01:   return 1'b1;
            2'b10:   return (ch % 2 == 0) ? ~ph : ph;
            default: return (pwm < duty);
        endcase
    endfunction

    task automatic model_clear(output model_t m);
        m.e = 0; m.ticks = 0; m.pcnt = 0; m.ph = 1'b0; m.lv = 16'h0;
    endtask

    task automatic model_edge(inout model_t m, input int div, input int nled,
                              input logic [31:0] md, input logic [15:0] hp);
        int lim;
        for (int ch = 0; ch < nled; ch++)
            m.lv[ch] = logic_val(md[2*ch +: 2], ch, m.ph, tri_duty(m.ticks), m.e % 256);
        if (m.e % div == div - 1) begin
            lim = (hp == 16'd0) ? 1 : int'(hp);
            if (m.pcnt >= lim - 1) begin
                m.pcnt = 0;
                m.ph   = ~m.ph;
            end else begin
                m.pcnt = m.pcnt + 1;
            end
            m.ticks = m.ticks + 1;
        end
        m.e = m.e + 1;
    endtask

    // Advance one clock; the model consumes the inputs held across the edge.
    task automatic cycle();
        @(posedge clk);
        if (rst_n) begin
            model_edge(ma, DIV_A, 2, {28'd0, mode_a}, hp_a);
            model_edge(mb, DIV_B, 4, {24'd0, mode_b}, hp_b);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_clear(ma);
        model_clear(mb);
        repeat (2) cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_clear(ma);
        model_clear(mb);
        repeat (3) cycle();
        n_checks++; if (tick_a !== 1'b0)    begin n_fail++; $display("FAIL reset tick_a got %b want 0", tick_a); end
        n_checks++; if (tick_b !== 1'b0)    begin n_fail++; $display("FAIL reset tick_b got %b want 0", tick_b); end
        n_checks++; if (phase_a !== 1'b0)   begin n_fail++; $display("FAIL reset phase_a got %b want 0", phase_a); end
        n_checks++; if (phase_b !== 1'b0)   begin n_fail++; $display("FAIL reset phase_b got %b want 0", phase_b); end
        n_checks++; if (led_a !== 2'b00)    begin n_fail++; $display("FAIL reset led_a got %b want 00", led_a); end
        n_checks++; if (led_b !== 4'b1111)  begin n_fail++; $display("FAIL reset led_b got %b want 1111", led_b); end
        rst_n = 1'b1;
    endtask

    task automatic test_tick_timing();
        logic want_a, want_b;
        mode_a = 4'b0000;
        do_reset();
        for (int k = 1; k <= 45; k++) begin
            cycle();
            want_a = ((k + 1) % DIV_A == 0);
            want_b = ((k + 1) % DIV_B == 0);
            n_checks++; if (tick_a !== want_a) begin n_fail++; $display("FAIL tick_timing k=%0d tick_a got %b want %b", k, tick_a, want_a); end
            n_checks++; if (tick_b !== want_b) begin n_fail++; $display("FAIL tick_timing k=%0d tick_b got %b want %b", k, tick_b, want_b); end
        end
    endtask

    task automatic test_blink();
        int  last_toggle;
        logic prev;
        mode_a = 4'b1010;
        hp_a   = 16'd3;
        do_reset();
        last_toggle = -1;
        prev = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            cycle();
            n_checks++; if (phase_a !== ma.ph)      begin n_fail++; $display("FAIL blink k=%0d phase got %b want %b", k, phase_a, ma.ph); end
            n_checks++; if (led_a !== ma.lv[1:0])   begin n_fail++; $display("FAIL blink k=%0d led got %b want %b", k, led_a, ma.lv[1:0]); end
            n_checks++; if (led_a[0] === led_a[1])  begin n_fail++; $display("FAIL blink_compl k=%0d led got %b want complementary", k, led_a); end
            if (phase_a !== prev) begin
                n_checks++;
                if (last_toggle < 0) begin
                    if (k != 30) begin n_fail++; $display("FAIL blink_first_toggle got cycle %0d want 30", k); end
                end else if (k - last_toggle != 30) begin
                    n_fail++; $display("FAIL blink_period got %0d want 30", k - last_toggle);
                end
                last_toggle = k;
                prev = phase_a;
            end
        end
    endtask

    task automatic test_hp_zero();
        int  toggles;
        int  waited;
        logic prev;
        bit  found;
        mode_a = 4'b1010;
        hp_a   = 16'd0;
        do_reset();
        toggles = 0;
        prev = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            cycle();
            n_checks++; if (phase_a !== ma.ph) begin n_fail++; $display("FAIL hp_zero k=%0d phase got %b want %b", k, phase_a, ma.ph); end
            if (phase_a !== prev) toggles++;
            prev = phase_a;
        end
        n_checks++; if (toggles != 10) begin n_fail++; $display("FAIL hp_zero_toggles got %0d want 10", toggles); end

        hp_a  = 16'd8;
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            cycle();
            if (ma.pcnt == 5) found = 1'b1;
        end
        n_checks++; if (!found) begin n_fail++; $display("FAIL hp_switch_reach got no count=5 want count=5 within 200 cycles"); end
        hp_a   = 16'd2;
        prev   = phase_a;
        waited = 0;
        found  = 1'b0;
        for (int k = 1; k <= 2 * DIV_A && !found; k++) begin
            cycle();
            if (phase_a !== prev) begin found = 1'b1; waited = k; end
        end
        n_checks++; if (!found || waited > DIV_A) begin n_fail++; $display("FAIL hp_switch_wrap got toggle after %0d cycles want <= %0d", waited, DIV_A); end
        n_checks++; if (phase_a !== ma.ph) begin n_fail++; $display("FAIL hp_switch_phase got %b want %b", phase_a, ma.ph); end
    endtask

    task automatic test_breathe();
        mode_b = 8'hFF;
        do_reset();
        for (int k = 1; k <= 1100; k++) begin
            cycle();
            n_checks++; if (led_b !== ~mb.lv[3:0]) begin n_fail++; $display("FAIL breathe k=%0d led_b got %b want %b", k, led_b, ~mb.lv[3:0]); end
        end
    endtask

    task automatic test_active_low();
        mode_b = 8'h01;
        cycle();
        n_checks++; if (led_b !== 4'b1110) begin n_fail++; $display("FAIL active_low_on got %b want 1110", led_b); end
        mode_b = 8'h00;
        cycle();
        n_checks++; if (led_b !== 4'b1111) begin n_fail++; $display("FAIL active_low_off got %b want 1111", led_b); end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 1; k <= 600; k++) begin
            if (k % 7 == 0) begin
                mode_a = 4'($urandom);
                mode_b = 8'($urandom);
            end
            if (k % 97 == 0) begin
                hp_a = 16'($urandom_range(0, 4));
                hp_b = 16'($urandom_range(0, 5));
            end
            cycle();
            n_checks++; if (led_a !== ma.lv[1:0])  begin n_fail++; $display("FAIL random k=%0d led_a got %b want %b", k, led_a, ma.lv[1:0]); end
            n_checks++; if (led_b !== ~mb.lv[3:0]) begin n_fail++; $display("FAIL random k=%0d led_b got %b want %b", k, led_b, ~mb.lv[3:0]); end
            n_checks++; if (phase_a !== ma.ph)     begin n_fail++; $display("FAIL random k=%0d phase_a got %b want %b", k, phase_a, ma.ph); end
            n_checks++; if (phase_b !== mb.ph)     begin n_fail++; $display("FAIL random k=%0d phase_b got %b want %b", k, phase_b, mb.ph); end
            n_checks++; if (tick_a !== (ma.e % DIV_A == DIV_A - 1)) begin n_fail++; $display("FAIL random k=%0d tick_a got %b", k, tick_a); end
        end
    endtask

    task automatic test_async_reset();
        logic want;
        mode_a = 4'b1010;
        mode_b = 8'h55;
        hp_a   = 16'd1;
        do_reset();
        repeat (37) cycle();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        model_clear(ma);
        model_clear(mb);
        #1;
        n_checks++; if (tick_a !== 1'b0)   begin n_fail++; $display("FAIL async_reset tick_a got %b want 0", tick_a); end
        n_checks++; if (tick_b !== 1'b0)   begin n_fail++; $display("FAIL async_reset tick_b got %b want 0", tick_b); end
        n_checks++; if (phase_a !== 1'b0)  begin n_fail++; $display("FAIL async_reset phase_a got %b want 0", phase_a); end
        n_checks++; if (led_a !== 2'b00)   begin n_fail++; $display("FAIL async_reset led_a got %b want 00", led_a); end
        n_checks++; if (led_b !== 4'b1111) begin n_fail++; $display("FAIL async_reset led_b got %b want 1111", led_b); end
        @(negedge clk);
        repeat (2) cycle();
        rst_n = 1'b1;
        for (int k = 1; k <= 35; k++) begin
            cycle();
            want = ((k + 1) % DIV_A == 0);
            n_checks++; if (tick_a !== want)   begin n_fail++; $display("FAIL async_release k=%0d tick_a got %b want %b", k, tick_a, want); end
            n_checks++; if (phase_a !== ma.ph) begin n_fail++; $display("FAIL async_release k=%0d phase_a got %b want %b", k, phase_a, ma.ph); end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_tick_timing();
        test_blink();
        test_hp_zero();
        test_breathe();
        test_active_low();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
